// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new-game/serve/play/game-over phases,
// keeps the BCD score and ball count, and gates the ball/paddle graphics.
module pong_game_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned PAUSE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reset,
    output logic [7:0] score,
    output logic [1:0] balls_left,
    output logic [1:0] game_state,
    output logic       game_over
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned BALLS_W = 2;

    typedef enum logic [1:0] {
        S_NEWGAME = 2'b00,
        S_PLAY    = 2'b01,
        S_NEWBALL = 2'b10,
        S_OVER    = 2'b11
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           btn_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 press_c;
    logic                 timer_done_c;

    logic                 gra_still_d;
    logic                 ball_reset_d;
    logic                 game_over_d;
    logic                 enter_pause_c;
    logic                 new_game_c;
    logic [SCORE_W-1:0]   score_d;
    logic [BALLS_W-1:0]   balls_d;

    // Rising edge of "any button down"; a held button never re-triggers.
    assign press_c      = (|btn) & ~(|btn_q);
    assign timer_done_c = (timer_q == '0);
    assign game_state   = state_q;

    // State and registered flow outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_NEWGAME;
            gra_still  <= 1'b1;
            ball_reset <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gra_still  <= gra_still_d;
            ball_reset <= ball_reset_d;
            game_over  <= game_over_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NEWGAME: if (press_c) state_d = S_PLAY;
            S_PLAY:    if (miss) state_d = (balls_left == BALLS_W'(1)) ? S_OVER : S_NEWBALL;
            S_NEWBALL: if (timer_done_c && press_c) state_d = S_PLAY;
            S_OVER:    if (timer_done_c) state_d = S_NEWGAME;
            default:   state_d = S_NEWGAME;
        endcase
    end

    // Output and datapath next values, all derived from the transition
    always_comb begin
        gra_still_d   = (state_d != S_PLAY);
        ball_reset_d  = (state_d == S_PLAY) && (state_q != S_PLAY);
        game_over_d   = (state_d == S_OVER);
        enter_pause_c = ((state_d == S_NEWBALL) || (state_d == S_OVER)) && (state_d != state_q);
        new_game_c    = (state_d == S_NEWGAME) && (state_q == S_OVER);

        score_d = score;
        if (new_game_c) begin
            score_d = '0;
        end else if ((state_q == S_PLAY) && hit && !miss && (score != 8'h99)) begin
            // BCD increment; 99 is excluded above so the tens digit never wraps
            if (score[3:0] == 4'd9) score_d = {score[7:4] + 4'd1, 4'd0};
            else                    score_d = {score[7:4], score[3:0] + 4'd1};
        end

        balls_d = balls_left;
        if (new_game_c) begin
            balls_d = BALLS_W'(BALLS);
        end else if ((state_q == S_PLAY) && miss && (balls_left != '0)) begin
            balls_d = balls_left - BALLS_W'(1);
        end
    end

    // Button history, pause timer, score and ball count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q      <= '0;
            timer_q    <= '0;
            score      <= '0;
            balls_left <= BALLS_W'(BALLS);
        end else begin
            btn_q      <= btn;
            score      <= score_d;
            balls_left <= balls_d;
            // A load on pause entry takes precedence over a coincident tick
            if (enter_pause_c)                   timer_q <= TIMER_W'(PAUSE_FRAMES);
            else if (refr_tick && !timer_done_c) timer_q <= timer_q - TIMER_W'(1);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus random
// play, each cycle checked against a decimal-arithmetic game model.
module tb_pong_game_ctrl;

    localparam int unsigned BALLS = 3;
    localparam int unsigned PF    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic       ball_reset;
    logic [7:0] score;
    logic [1:0] balls_left;
    logic [1:0] game_state;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 new game, 1 play, 2 serve, 3 over
    int m_phase, m_score, m_balls, m_timer, m_prev_btn;
    bit m_ball_reset;

    pong_game_ctrl #(.BALLS(BALLS), .PAUSE_FRAMES(PF)) dut (
        .clk(clk), .rst(rst), .refr_tick(refr_tick), .btn(btn), .hit(hit), .miss(miss),
        .gra_still(gra_still), .ball_reset(ball_reset), .score(score),
        .balls_left(balls_left), .game_state(game_state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens, units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_balls = BALLS; m_timer = 0; m_prev_btn = 0;
        m_ball_reset = 1'b0;
    endtask

    task automatic model_step(input int b, input bit h, input bit m, input bit tk);
        bit pr;
        bit pause_done;
        pr = (b != 0) && (m_prev_btn == 0);
        m_prev_btn = b;
        pause_done = (m_timer == 0);
        m_ball_reset = 1'b0;
        if (tk && m_timer > 0) m_timer--;
        case (m_phase)
            0: if (pr) begin m_phase = 1; m_ball_reset = 1'b1; end
            1: begin
                if (m) begin
                    m_balls--;
                    m_phase = (m_balls == 0) ? 3 : 2;
                    m_timer = PF;
                end else if (h && m_score < 99) begin
                    m_score++;
                end
            end
            2: if (pause_done && pr) begin m_phase = 1; m_ball_reset = 1'b1; end
            default: if (pause_done) begin m_phase = 0; m_score = 0; m_balls = BALLS; end
        endcase
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ":state"}, 32'(game_state), 32'(m_phase));
        check_eq({tag, ":still"}, 32'(gra_still), 32'(m_phase != 1));
        check_eq({tag, ":over"}, 32'(game_over), 32'(m_phase == 3));
        check_eq({tag, ":breset"}, 32'(ball_reset), 32'(m_ball_reset));
        check_eq({tag, ":score"}, 32'(score), 32'(to_bcd(m_score)));
        check_eq({tag, ":balls"}, 32'(balls_left), 32'(m_balls));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ":state"}, 32'(game_state), 32'd0);
        check_eq({tag, ":still"}, 32'(gra_still), 32'd1);
        check_eq({tag, ":breset"}, 32'(ball_reset), 32'd0);
        check_eq({tag, ":score"}, 32'(score), 32'h00);
        check_eq({tag, ":balls"}, 32'(balls_left), 32'(BALLS));
        check_eq({tag, ":over"}, 32'(game_over), 32'd0);
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge
    task automatic step(input string tag, input logic [1:0] b, input bit h, input bit m, input bit tk);
        @(negedge clk);
        btn = b; hit = h; miss = m; refr_tick = tk;
        model_step(int'(b), h, m, tk);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic press(input string tag);
        step(tag, 2'b01, 1'b0, 1'b0, 1'b0);
        step(tag, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input string tag, input int n, input logic [1:0] b);
        for (int i = 0; i < n; i++) step(tag, b, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic hits(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; btn = '0; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;
        step("idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Single press starts play with exactly one ball_reset pulse
        press("start");
        check_eq("start:state", 32'(game_state), 32'd1);
        check_eq("start:breset_gone", 32'(ball_reset), 32'd0);

        // BCD counting and saturation
        hits("bcd9", 9);
        check_eq("bcd:09", 32'(score), 32'h09);
        hits("bcd19", 10);
        check_eq("bcd:19", 32'(score), 32'h19);
        hits("bcd99", 85);
        check_eq("bcd:99", 32'(score), 32'h99);

        // Miss, early press ignored, serve after full pause
        step("miss1", 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("miss1:state", 32'(game_state), 32'd2);
        check_eq("miss1:balls", 32'(balls_left), 32'd2);
        ticks("wait2", 2, 2'b00);
        press("early");
        check_eq("early:state", 32'(game_state), 32'd2);
        ticks("wait4", 2, 2'b00);
        step("serve", 2'b01, 1'b0, 1'b0, 1'b0);
        check_eq("serve:breset", 32'(ball_reset), 32'd1);
        step("serve_rel", 2'b00, 1'b0, 1'b0, 1'b0);

        // Remaining balls to game over, then recycle
        step("miss2", 2'b00, 1'b0, 1'b1, 1'b0);
        ticks("wait_m2", 4, 2'b00);
        press("serve2");
        step("miss3", 2'b00, 1'b0, 1'b1, 1'b1);
        check_eq("over:state", 32'(game_state), 32'd3);
        check_eq("over:flag", 32'(game_over), 32'd1);
        check_eq("over:balls", 32'(balls_left), 32'd0);
        press("over_press");
        ticks("over_wait", 4, 2'b00);
        step("recycle", 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("recycle:state", 32'(game_state), 32'd0);
        check_eq("recycle:score", 32'(score), 32'h00);
        check_eq("recycle:balls", 32'(balls_left), 32'd3);

        // Simultaneous hit and miss: miss wins
        press("start2");
        hits("to5", 5);
        step("hitmiss", 2'b00, 1'b1, 1'b1, 1'b0);
        check_eq("hitmiss:score", 32'(score), 32'h05);
        check_eq("hitmiss:balls", 32'(balls_left), 32'd2);
        check_eq("hitmiss:state", 32'(game_state), 32'd2);

        // Button held from serve entry past timer_done
        step("hold0", 2'b10, 1'b0, 1'b0, 1'b0);
        ticks("hold_t", 4, 2'b10);
        for (int i = 0; i < 3; i++) step("hold", 2'b11, 1'b0, 1'b0, 1'b0);
        check_eq("hold:state", 32'(game_state), 32'd2);
        step("hold_rel", 2'b00, 1'b0, 1'b0, 1'b0);
        press("repress");
        check_eq("repress:state", 32'(game_state), 32'd1);

        // Asynchronous reset mid-cycle in PLAY
        hits("pre_rst", 3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 2'b00, 1'b0, 1'b0, 1'b0);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step("rand", rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the FPGA Pong design. It sequences play through new-game, serve, play and game-over phases, and counts score and remaining balls. It freezes or releases the ball/paddle graphics and requests ball re-centring. It sits beside the VGA sync and pixel generation circuit. It consumes the frame refresh tick and the hit/miss events from pixel generation, and the button inputs from the board.

## Interface
- BALLS, 3: balls per game; legal range 1..3.
- PAUSE_FRAMES, 120: frames to pause after a miss or game over (2 s at 60 Hz); legal range 1..255.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- refr_tick  in  1  one-clk pulse per video frame (start of vertical blank).
- btn  in  2  paddle buttons; synchronous and debounced upstream.
- hit  in  1  one-clk pulse when the ball strikes the paddle.
- miss  in  1  one-clk pulse when the ball passes the paddle.
- gra_still  out  1  1 = freeze ball/paddle motion.
- ball_reset  out  1  one-clk pulse: re-centre the ball and restore its default velocity.
- score  out  8  two BCD digits, [7:4] tens and [3:0] units.
- balls_left  out  2  balls remaining, including the one in play.
- game_state  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER; drives text overlay selection.
- game_over  out  1  1 while in OVER.

## Operation
- Press detect: btn_q registers btn. press = (|btn) & ~(|btn_q).
- Pause timer: 8-bit down-counter.
  - Loaded with PAUSE_FRAMES on entry to NEWBALL or OVER.
  - Decrements on each refr_tick while nonzero.
  - timer_done = (timer == 0).
- FSM states:
  - NEWGAME: gra_still=1. On press → PLAY.
  - PLAY: gra_still=0.
    - On miss with balls_left==1 → OVER; balls_left becomes 0.
    - On miss with balls_left>1 → NEWBALL; balls_left decrements by 1.
  - NEWBALL: gra_still=1. Press is ignored until timer_done. Press with timer_done → PLAY.
  - OVER: gra_still=1, game_over=1. When timer_done → NEWGAME. Press is ignored.
- On entry to NEWGAME (from OVER): score←8'h00, balls_left←BALLS.
- ball_reset: pulses for one clk on every entry to PLAY, from either NEWGAME or NEWBALL.
- Score:
  - In PLAY only, each hit increments the BCD score.
  - Units wrap 9→0 with a carry into the tens digit.
  - Score saturates at 8'h99.
  - hit in any state other than PLAY is ignored.
- hit and miss in the same cycle: miss wins; score is unchanged.
- refr_tick coinciding with a timer load: the load wins; that tick is not counted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values (rst low, applied asynchronously):
  - state NEWGAME, game_state 2'b00
  - gra_still 1, ball_reset 0
  - score 8'h00, balls_left BALLS, game_over 0
  - timer 0, btn_q 0
- Release of rst is sampled synchronously. The first press may be detected on the second clk edge after release.
- Latency from event to output: one clk.
  - A press or miss at edge n gives the new game_state, gra_still and balls_left after edge n.
  - ball_reset is high during the cycle after the edge that enters PLAY.
  - A hit at edge n gives the updated score after edge n.
- NEWBALL/OVER dwell: from entry, PAUSE_FRAMES refr_ticks are needed before timer_done. Exit occurs on the first clk where timer_done (OVER) or timer_done & press (NEWBALL).
- Held buttons: a button held across a state change does not generate a new press. It must be released (btn==0 for ≥1 clk) and pressed again.
- Reset mid-game: asserting rst in any state returns all outputs to their reset values within the same cycle (asynchronous).

## Test plan
Benches use BALLS=3 and PAUSE_FRAMES=4 unless stated.

- Reset then single press:
  - Stimulus: rst low for 3 clk, release, btn=2'b01 for 1 clk.
  - Required: game_state 01, gra_still 0, ball_reset high for exactly 1 clk, balls_left 3, score 8'h00.
- Score BCD and saturation:
  - Stimulus: in PLAY, 9 hit pulses, then 10 more, then 85 more.
  - Required: score 8'h09, then 8'h19, then 8'h99 and held there (no wrap).
- Miss and serve:
  - Stimulus: in PLAY, a miss.
  - Required: game_state 10, balls_left 2, gra_still 1.
  - Stimulus: press after 2 refr_ticks.
  - Required: press ignored.
  - Stimulus: press after 4 refr_ticks total.
  - Required: → PLAY with a ball_reset pulse.
- Game over and recycle:
  - Stimulus: three misses, each NEWBALL served after the timer.
  - Required: after the third miss, game_state 11, game_over 1, balls_left 0.
  - Stimulus: 4 refr_ticks.
  - Required: NEWGAME, score 8'h00, balls_left 3.
- Simultaneous hit+miss:
  - Stimulus: score 8'h05 in PLAY, hit and miss in the same clk.
  - Required: score stays 8'h05, balls_left decrements, state NEWBALL.
- Held button and async reset:
  - Stimulus: btn held high from NEWBALL entry past timer_done.
  - Required: no PLAY entry until btn is released and re-pressed.
  - Stimulus: rst asserted mid-clock in PLAY.
  - Required: outputs at reset values immediately, before the next clk edge.
